// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and sequencing controller for the five-stage RV32 pipeline.
// Drives stall/flush for IF, ID and EX and the fetch redirect from load-use,
// branch-operand and memory-wait hazards, with a pending-redirect replay slot.
// Optional lost-cycle counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int unsigned RegAddrWidth = 5,
    parameter int unsigned PcWidth      = 32
`ifdef PIPE_CTRL_PERF_EN
    ,
    parameter int unsigned CntWidth     = 32
`endif
) (
    input  logic                    iClk,
    input  logic                    nRst,
    input  logic [RegAddrWidth-1:0] iIdRs1,
    input  logic [RegAddrWidth-1:0] iIdRs2,
    input  logic                    iIdRs1En,
    input  logic                    iIdRs2En,
    input  logic                    iIdBranch,
    input  logic                    iBrTrue,
    input  logic [PcWidth-1:0]      iBrPc,
    input  logic [RegAddrWidth-1:0] iExRd,
    input  logic                    iExWb,
    input  logic                    iExLoad,
    input  logic                    iExValid,
    input  logic [RegAddrWidth-1:0] iMemRd,
    input  logic                    iMemLoad,
    input  logic                    iMemValid,
    input  logic                    iMemReq,
    input  logic                    iMemAck,
    output logic                    oStallIF,
    output logic                    oStallID,
    output logic                    oStallEX,
    output logic                    oFlushIF,
    output logic                    oFlushID,
    output logic                    oPcSel,
    output logic [PcWidth-1:0]      oPcNext
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CntWidth-1:0]     oCntStall,
    output logic [CntWidth-1:0]     oCntFlush
`endif
);

    typedef enum logic [0:0] {StRun, StMemWait} state_e;

    state_e               state_q, state_d;
    logic                 pend_q, pend_d;
    logic [PcWidth-1:0]   pend_pc_q, pend_pc_d;
    logic                 stall_mem;
    logic                 hazard;
    logic                 replay;
    logic                 redirect;

    // True when the ID instruction reads a non-x0 register equal to rd.
    function automatic logic src_match(input logic [RegAddrWidth-1:0] rd);
        return (rd != '0) &&
               ((iIdRs1En && (iIdRs1 == rd)) || (iIdRs2En && (iIdRs2 == rd)));
    endfunction

    // State and pending-redirect registers.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= StRun;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // Next state, hazard decode and pending-redirect update.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        unique case (state_q)
            StRun:     if (iMemReq && !iMemAck) state_d = StMemWait;
            StMemWait: if (iMemAck)             state_d = StRun;
            default:                            state_d = StRun;
        endcase
        // The ack cycle already lets the pipe advance, so stall only while the
        // next state is still the wait state.
        stall_mem = (state_d == StMemWait);
        hazard    = !stall_mem &&
                    ((iExValid && iExLoad && src_match(iExRd)) ||
                     (iIdBranch && ((iExValid && iExWb && src_match(iExRd)) ||
                                    (iMemValid && iMemLoad && src_match(iMemRd)))));
        // A pending target wins over a fresh iBrTrue, which belongs to the
        // slot the replay flushes.
        replay    = !stall_mem && !hazard && pend_q;
        redirect  = !stall_mem && !hazard && !pend_q && iBrTrue;
        if (stall_mem && iBrTrue) begin
            pend_d    = 1'b1;
            pend_pc_d = iBrPc;
        end else if (replay) begin
            pend_d    = 1'b0;
        end
    end

    // Stall/flush/redirect outputs, forced low while reset is asserted.
    always_comb begin
        oStallIF = nRst && (stall_mem || hazard);
        oStallID = nRst && (stall_mem || hazard);
        oStallEX = nRst && stall_mem;
        oFlushID = nRst && hazard;
        oFlushIF = nRst && (replay || redirect);
        oPcSel   = nRst && (replay || redirect);
        oPcNext  = '0;
        if (oPcSel) oPcNext = replay ? pend_pc_q : iBrPc;
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CntWidth-1:0] cnt_stall_q;
    logic [CntWidth-1:0] cnt_flush_q;

    // Saturating lost-cycle counters.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            cnt_stall_q <= '0;
            cnt_flush_q <= '0;
        end else begin
            if (oStallIF && (cnt_stall_q != '1)) cnt_stall_q <= cnt_stall_q + CntWidth'(1);
            if ((oFlushIF || oFlushID) && (cnt_flush_q != '1)) begin
                cnt_flush_q <= cnt_flush_q + CntWidth'(1);
            end
        end
    end

    assign oCntStall = cnt_stall_q;
    assign oCntFlush = cnt_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed-vector bench for pipe_ctrl with hand-computed
// expectations; counter checks are built when PIPE_CTRL_PERF_EN is defined.
module tb_pipe_ctrl;

    logic        iClk;
    logic        nRst;
    logic [4:0]  iIdRs1, iIdRs2, iExRd, iMemRd;
    logic        iIdRs1En, iIdRs2En, iIdBranch, iBrTrue;
    logic [31:0] iBrPc;
    logic        iExWb, iExLoad, iExValid, iMemLoad, iMemValid, iMemReq, iMemAck;
    logic        oStallIF, oStallID, oStallEX, oFlushIF, oFlushID, oPcSel;
    logic [31:0] oPcNext;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] oCntStall, oCntFlush;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pipe_ctrl dut (
        .iClk      (iClk),
        .nRst      (nRst),
        .iIdRs1    (iIdRs1),
        .iIdRs2    (iIdRs2),
        .iIdRs1En  (iIdRs1En),
        .iIdRs2En  (iIdRs2En),
        .iIdBranch (iIdBranch),
        .iBrTrue   (iBrTrue),
        .iBrPc     (iBrPc),
        .iExRd     (iExRd),
        .iExWb     (iExWb),
        .iExLoad   (iExLoad),
        .iExValid  (iExValid),
        .iMemRd    (iMemRd),
        .iMemLoad  (iMemLoad),
        .iMemValid (iMemValid),
        .iMemReq   (iMemReq),
        .iMemAck   (iMemAck),
        .oStallIF  (oStallIF),
        .oStallID  (oStallID),
        .oStallEX  (oStallEX),
        .oFlushIF  (oFlushIF),
        .oFlushID  (oFlushID),
        .oPcSel    (oPcSel),
        .oPcNext   (oPcNext)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .oCntStall (oCntStall),
        .oCntFlush (oCntFlush)
`endif
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // exp bits: {StallIF, StallID, StallEX, FlushIF, FlushID, PcSel}
    task automatic check_out(input string tag, input logic [5:0] exp, input logic [31:0] pc);
        check({tag, ".ctl"}, {26'd0, oStallIF, oStallID, oStallEX, oFlushIF, oFlushID, oPcSel},
              {26'd0, exp});
        check({tag, ".pc"}, oPcNext, pc);
    endtask

    task automatic idle();
        iIdRs1 = '0; iIdRs2 = '0; iIdRs1En = 0; iIdRs2En = 0; iIdBranch = 0;
        iBrTrue = 0; iBrPc = '0; iExRd = '0; iExWb = 0; iExLoad = 0; iExValid = 0;
        iMemRd = '0; iMemLoad = 0; iMemValid = 0; iMemReq = 0; iMemAck = 0;
    endtask

    // Start a new cycle: inputs change just after the rising edge.
    task automatic next_cycle();
        @(posedge iClk);
        #1;
        idle();
    endtask

    // Sample outputs on the falling edge.
    task automatic sample(input string tag, input logic [5:0] exp, input logic [31:0] pc);
        @(negedge iClk);
        check_out(tag, exp, pc);
    endtask

    localparam logic [5:0] Quiet  = 6'b000000;
    localparam logic [5:0] Bubble = 6'b110010;
    localparam logic [5:0] MemStl = 6'b111000;
    localparam logic [5:0] Redir  = 6'b000101;

    initial begin
        idle();
        nRst = 1'b0;
        iBrTrue = 1; iBrPc = 32'h55; iMemReq = 1;
        #3;
        check_out("reset", Quiet, 32'h0);
        #4;
        idle();
        nRst = 1'b1;

        // Load-use: lw x5 in EX, ID reads x5 -> one bubble.
        next_cycle();
        iExValid = 1; iExLoad = 1; iExWb = 1; iExRd = 5; iIdRs1 = 5; iIdRs1En = 1;
        sample("loaduse", Bubble, 32'h0);
        next_cycle();
        iMemValid = 1; iMemLoad = 1; iMemRd = 5; iIdRs1 = 5; iIdRs1En = 1;
        sample("loaduse_after", Quiet, 32'h0);
`ifdef PIPE_CTRL_PERF_EN
        @(posedge iClk); #1;
        check("cnt_stall_lu", oCntStall, 32'd1);
        check("cnt_flush_lu", oCntFlush, 32'd1);
`endif

        // x0 and unread sources never hazard.
        next_cycle();
        iExValid = 1; iExLoad = 1; iExRd = 0; iIdRs1 = 0; iIdRs1En = 1;
        sample("x0", Quiet, 32'h0);
        next_cycle();
        iExValid = 1; iExLoad = 1; iExRd = 9; iIdRs2 = 9; iIdRs2En = 0;
        sample("rs_dis", Quiet, 32'h0);

        // Branch on ALU result in EX: one bubble, redirect suppressed.
        next_cycle();
        iIdBranch = 1; iIdRs2 = 7; iIdRs2En = 1; iExValid = 1; iExWb = 1; iExRd = 7;
        iBrTrue = 1; iBrPc = 32'h300;
        sample("br_alu", Bubble, 32'h0);
        next_cycle();
        iIdBranch = 1; iIdRs2 = 7; iIdRs2En = 1; iMemValid = 1; iMemRd = 7;
        iBrTrue = 1; iBrPc = 32'h300;
        sample("br_alu_go", Redir, 32'h300);

        // Branch on load: two bubbles, then redirect.
        next_cycle();
        iIdBranch = 1; iIdRs1 = 7; iIdRs1En = 1; iExValid = 1; iExLoad = 1; iExWb = 1;
        iExRd = 7; iBrTrue = 1; iBrPc = 32'h340;
        sample("br_ld1", Bubble, 32'h0);
        next_cycle();
        iIdBranch = 1; iIdRs1 = 7; iIdRs1En = 1; iMemValid = 1; iMemLoad = 1; iMemRd = 7;
        iBrTrue = 1; iBrPc = 32'h340;
        sample("br_ld2", Bubble, 32'h0);
        next_cycle();
        iIdBranch = 1; iIdRs1 = 7; iIdRs1En = 1; iBrTrue = 1; iBrPc = 32'h340;
        sample("br_ld_go", Redir, 32'h340);

        // Plain taken branch.
        next_cycle();
        iBrTrue = 1; iBrPc = 32'h100;
        sample("taken", Redir, 32'h100);
        next_cycle();
        sample("taken_after", Quiet, 32'h0);

        // Memory wait of 3 cycles with a load-use also present: stall only.
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            iMemReq = 1;
            iExValid = 1; iExLoad = 1; iExRd = 3; iIdRs1 = 3; iIdRs1En = 1;
            sample($sformatf("memwait%0d", i), MemStl, 32'h0);
        end
        next_cycle();
        iMemReq = 1; iMemAck = 1;
        sample("memack", Quiet, 32'h0);

        // Same-cycle ack never stalls.
        next_cycle();
        iMemReq = 1; iMemAck = 1;
        sample("same_ack", Quiet, 32'h0);
        next_cycle();
        sample("same_ack_after", Quiet, 32'h0);

        // Redirect during memory wait is held, then replayed on the ack cycle.
        next_cycle();
        iMemReq = 1;
        sample("pend_w0", MemStl, 32'h0);
        next_cycle();
        iMemReq = 1; iBrTrue = 1; iBrPc = 32'h200;
        sample("pend_w1", MemStl, 32'h0);
        next_cycle();
        iMemReq = 1; iMemAck = 1; iBrTrue = 1; iBrPc = 32'h999;
        sample("pend_replay", Redir, 32'h200);
        next_cycle();
        sample("pend_clear", Quiet, 32'h0);

        // Reset mid-wait with a pending redirect: no replay afterwards.
        next_cycle();
        iMemReq = 1;
        sample("rst_w0", MemStl, 32'h0);
        next_cycle();
        iMemReq = 1; iBrTrue = 1; iBrPc = 32'h400;
        sample("rst_w1", MemStl, 32'h0);
        next_cycle();
        iMemReq = 1;
        #2;
        nRst = 1'b0;
        #1;
        check_out("rst_async", Quiet, 32'h0);
`ifdef PIPE_CTRL_PERF_EN
        check("cnt_stall_rst", oCntStall, 32'd0);
        check("cnt_flush_rst", oCntFlush, 32'd0);
`endif
        @(negedge iClk);
        idle();
        nRst = 1'b1;
        next_cycle();
        iMemAck = 1;
        sample("rst_no_replay", Quiet, 32'h0);
        next_cycle();
        sample("rst_idle", Quiet, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
